// File: rtl/peripheral_spram_clr.sv
// Single-port synchronous RAM with byte-lane writes, a registered read port and a
// hardware clear sequencer that sweeps INIT_VAL into every word after reset or on request.
module peripheral_spram_clr #(
  parameter int             AW       = 7,
  parameter int             DW       = 16,
  parameter int             MEM_SIZE = 256,
  parameter logic [DW-1:0]  INIT_VAL = '0
) (
  input  logic            ram_clk,
  input  logic            ram_rstn,
  input  logic [AW-1:0]   ram_addr,
  input  logic [DW-1:0]   ram_din,
  input  logic            ram_cen,
  input  logic [DW/8-1:0] ram_wen,
  input  logic            ram_clr,
  output logic [DW-1:0]   ram_dout,
  output logic            ram_dvalid,
  output logic            ram_busy,
  output logic            ram_err
);
  localparam int NB    = DW / 8;
  localparam int DEPTH = MEM_SIZE / NB;
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   clr_ptr_q, clr_ptr_d;
  logic [DW-1:0]   dout_q, dout_d;
  logic            dvalid_q, dvalid_d;
  logic            err_q, err_d;

  logic [DW-1:0]   mem [DEPTH];
  logic [PW-1:0]   idx;
  logic            in_range, sweep_we, acc_we;

  // Upper address bits only matter for the range check; no aliasing into the array.
  assign idx      = ram_addr[PW-1:0];
  assign in_range = 32'(ram_addr) < 32'(DEPTH);

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    dout_d    = dout_q;
    dvalid_d  = 1'b0;
    err_d     = 1'b0;
    sweep_we  = 1'b0;
    acc_we    = 1'b0;

    case (state_q)
      CLEAR: begin
        sweep_we = 1'b1;
        if (ram_clr) begin
          clr_ptr_d = '0;
        end else if (clr_ptr_q == PW'(DEPTH - 1)) begin
          clr_ptr_d = '0;
          state_d   = IDLE;
        end else begin
          clr_ptr_d = clr_ptr_q + PW'(1);
        end
      end
      default: begin
        if (ram_clr) begin
          state_d   = CLEAR;
          clr_ptr_d = '0;
        end
      end
    endcase

    // Busy or colliding-with-clear accesses are dropped; dout keeps its value.
    if (!ram_cen) begin
      if (state_q != IDLE || ram_clr) begin
        err_d = 1'b1;
      end else if (!in_range) begin
        dout_d   = '0;
        dvalid_d = 1'b1;
        err_d    = 1'b1;
      end else begin
        dout_d   = mem[idx];
        dvalid_d = 1'b1;
        acc_we   = 1'b1;
      end
    end
  end

  always_ff @(posedge ram_clk or negedge ram_rstn) begin
    if (!ram_rstn) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
      dout_q    <= '0;
      dvalid_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      dout_q    <= dout_d;
      dvalid_q  <= dvalid_d;
      err_q     <= err_d;
    end
  end

  // Array has no reset; the sweep is its only initialisation.
  always_ff @(posedge ram_clk) begin
    if (sweep_we) begin
      mem[clr_ptr_q] <= INIT_VAL;
    end else if (acc_we) begin
      for (int i = 0; i < NB; i++) begin
        if (!ram_wen[i]) mem[idx][8*i +: 8] <= ram_din[8*i +: 8];
      end
    end
  end

  assign ram_dout   = dout_q;
  assign ram_dvalid = dvalid_q;
  assign ram_err    = err_q;
  assign ram_busy   = (state_q == CLEAR);
endmodule

// File: tb/tb_peripheral_spram_clr.sv
// Bench for peripheral_spram_clr (DW=16, DEPTH=128, AW=8): vector table plus
// hand-written clear/reset sequences, expectations queued per access.
module tb_peripheral_spram_clr;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  ram_addr;
  logic [15:0] ram_din;
  logic        ram_cen;
  logic [1:0]  ram_wen;
  logic        ram_clr;
  logic [15:0] ram_dout;
  logic        ram_dvalid, ram_busy, ram_err;

  int checks = 0;
  int failures = 0;

  peripheral_spram_clr #(.AW(8), .DW(16), .MEM_SIZE(256), .INIT_VAL(16'h0000)) dut (
    .ram_clk(clk), .ram_rstn(rst_n), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_cen(ram_cen), .ram_wen(ram_wen), .ram_clr(ram_clr), .ram_dout(ram_dout),
    .ram_dvalid(ram_dvalid), .ram_busy(ram_busy), .ram_err(ram_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        cen;
    logic [1:0]  wen;
    logic [7:0]  addr;
    logic [15:0] din;
    logic        dv;
    logic        er;
    logic [15:0] dout;
  } vec_t;

  typedef struct {
    logic        dv;
    logic        er;
    logic [15:0] dout;
    logic        chkd;
  } exp_t;

  vec_t vt[18];
  exp_t sb[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input string nm, input logic cen, input logic clr,
                       input logic [1:0] wen, input logic [7:0] addr, input logic [15:0] din,
                       input logic edv, input logic eer, input logic [15:0] edout,
                       input logic chkd);
    exp_t e;
    ram_cen = cen; ram_clr = clr; ram_wen = wen; ram_addr = addr; ram_din = din;
    e.dv = edv; e.er = eer; e.dout = edout; e.chkd = chkd;
    sb.push_back(e);
    step();
    ram_cen = 1'b1; ram_clr = 1'b0; ram_wen = 2'b11;
    if (sb.size() == 0) begin
      chk({nm, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({nm, "_dvalid"}, 32'(ram_dvalid), 32'(e.dv));
      chk({nm, "_err"}, 32'(ram_err), 32'(e.er));
      if (e.chkd) chk({nm, "_dout"}, 32'(ram_dout), 32'(e.dout));
    end
  endtask

  task automatic count_busy(input string nm);
    int n;
    n = 0;
    while (ram_busy === 1'b1 && n < 1000) begin
      n++;
      step();
    end
    chk(nm, 32'(n), 32'd128);
  endtask

  task automatic pulse_clr();
    ram_clr = 1'b1;
    step();
    ram_clr = 1'b0;
  endtask

  initial begin
    //             cen   wen    addr    din       dv    er    dout
    vt[0]  = '{1'b0, 2'b11, 8'd0,   16'h0000, 1'b1, 1'b0, 16'h0000};
    vt[1]  = '{1'b0, 2'b11, 8'd64,  16'h0000, 1'b1, 1'b0, 16'h0000};
    vt[2]  = '{1'b0, 2'b11, 8'd127, 16'h0000, 1'b1, 1'b0, 16'h0000};
    vt[3]  = '{1'b0, 2'b00, 8'd5,   16'hA5C3, 1'b1, 1'b0, 16'h0000};
    vt[4]  = '{1'b0, 2'b11, 8'd5,   16'h0000, 1'b1, 1'b0, 16'hA5C3};
    vt[5]  = '{1'b0, 2'b10, 8'd5,   16'h1234, 1'b1, 1'b0, 16'hA5C3};
    vt[6]  = '{1'b0, 2'b11, 8'd5,   16'h0000, 1'b1, 1'b0, 16'hA534};
    vt[7]  = '{1'b0, 2'b01, 8'd5,   16'h77FF, 1'b1, 1'b0, 16'hA534};
    vt[8]  = '{1'b0, 2'b11, 8'd5,   16'h0000, 1'b1, 1'b0, 16'h7734};
    vt[9]  = '{1'b0, 2'b11, 8'd5,   16'hDEAD, 1'b1, 1'b0, 16'h7734};
    vt[10] = '{1'b0, 2'b11, 8'd5,   16'h0000, 1'b1, 1'b0, 16'h7734};
    vt[11] = '{1'b0, 2'b00, 8'd5,   16'hFFFF, 1'b1, 1'b0, 16'h7734};
    vt[12] = '{1'b0, 2'b11, 8'd5,   16'h0000, 1'b1, 1'b0, 16'hFFFF};
    vt[13] = '{1'b0, 2'b00, 8'd72,  16'hBEEF, 1'b1, 1'b0, 16'h0000};
    vt[14] = '{1'b0, 2'b00, 8'd200, 16'h1111, 1'b1, 1'b1, 16'h0000};
    vt[15] = '{1'b0, 2'b11, 8'd72,  16'h0000, 1'b1, 1'b0, 16'hBEEF};
    vt[16] = '{1'b1, 2'b00, 8'd72,  16'h2222, 1'b0, 1'b0, 16'hBEEF};
    vt[17] = '{1'b0, 2'b11, 8'd200, 16'h0000, 1'b1, 1'b1, 16'h0000};

    rst_n = 1'b0; ram_cen = 1'b1; ram_clr = 1'b0; ram_wen = 2'b11;
    ram_addr = '0; ram_din = '0;
    repeat (3) step();
    chk("rst_dout", 32'(ram_dout), 32'd0);
    chk("rst_dvalid", 32'(ram_dvalid), 32'd0);
    chk("rst_err", 32'(ram_err), 32'd0);
    chk("rst_busy", 32'(ram_busy), 32'd1);
    rst_n = 1'b1;
    count_busy("init_busy_cycles");

    foreach (vt[i])
      drive($sformatf("vec%0d", i), vt[i].cen, 1'b0, vt[i].wen, vt[i].addr, vt[i].din,
            vt[i].dv, vt[i].er, vt[i].dout, 1'b1);

    // Clear from IDLE wipes the words written above.
    pulse_clr();
    count_busy("clr_busy_cycles");
    for (int a = 0; a < 128; a++)
      drive($sformatf("clr_word%0d", a), 1'b0, 1'b0, 2'b11, 8'(a), 16'h0, 1'b1, 1'b0, 16'h0, 1'b1);

    // Access while busy is dropped; a clear mid-sweep restarts the full sweep.
    pulse_clr();
    drive("busy_acc", 1'b0, 1'b0, 2'b00, 8'd3, 16'h3333, 1'b0, 1'b1, 16'h0, 1'b0);
    drive("busy_idle", 1'b1, 1'b0, 2'b11, 8'd3, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
    repeat (50) step();
    pulse_clr();
    count_busy("restart_busy_cycles");
    drive("busy_acc_word3", 1'b0, 1'b0, 2'b11, 8'd3, 16'h0, 1'b1, 1'b0, 16'h0, 1'b1);

    // Access colliding with a clear request.
    drive("clr_collide", 1'b0, 1'b1, 2'b00, 8'd9, 16'h1234, 1'b0, 1'b1, 16'h0, 1'b0);
    count_busy("collide_busy_cycles");
    drive("collide_word9", 1'b0, 1'b0, 2'b11, 8'd9, 16'h0, 1'b1, 1'b0, 16'h0, 1'b1);

    // Reset 40 cycles into a sweep.
    drive("pre_rst_wr", 1'b0, 1'b0, 2'b00, 8'd10, 16'h5A5A, 1'b1, 1'b0, 16'h0, 1'b1);
    drive("pre_rst_rd", 1'b0, 1'b0, 2'b11, 8'd10, 16'h0, 1'b1, 1'b0, 16'h5A5A, 1'b1);
    pulse_clr();
    repeat (39) step();
    chk("sweep_hold_dout", 32'(ram_dout), 32'h5A5A);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(ram_busy), 32'd1);
    chk("midrst_dout", 32'(ram_dout), 32'd0);
    chk("midrst_dvalid", 32'(ram_dvalid), 32'd0);
    repeat (2) step();
    rst_n = 1'b1;
    count_busy("midrst_busy_cycles");
    drive("post_rst_word10", 1'b0, 1'b0, 2'b11, 8'd10, 16'h0, 1'b1, 1'b0, 16'h0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
